// File: rtl/fpu_op_sequencer.sv
// Single-requester sequencer around a combinational FPU: launch, wait out latency, capture, write back.
// Optional one-entry request buffer enabled by the FPU_SEQ_QUEUE_EN macro.
module fpu_op_sequencer #(
    parameter int LATENCY = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic [4:0]  req_rd,
    output logic [31:0] fpu_a,
    output logic [31:0] fpu_b,
    output logic [3:0]  fpu_op,
    input  logic [31:0] fpu_result,
    input  logic        fpu_cc,
    input  logic        fpu_invalid,
    input  logic        fpu_overflow,
    input  logic        fpu_underflow,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        cc_out,
    output logic        busy,
    output logic [2:0]  flags_sticky,
    input  logic        flags_clr
);
    localparam int LAT_EFF = (LATENCY < 1) ? 1 : LATENCY;
    localparam int CNT_W   = $clog2(LAT_EFF + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, DONE = 2'd2} state_t;

    function automatic logic is_write(input logic [3:0] op);
        return (op == 4'b0001) || (op == 4'b0010) || (op == 4'b0110);
    endfunction

    function automatic logic is_cmp(input logic [3:0] op);
        return (op == 4'b0011) || (op == 4'b0100) || (op == 4'b0101) ||
               (op == 4'b0111) || (op == 4'b1000);
    endfunction

    function automatic logic [CNT_W-1:0] op_cnt(input logic [3:0] op);
        return ((op == 4'b0001) || (op == 4'b0010)) ? CNT_W'(LAT_EFF) : CNT_W'(1);
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
    logic [3:0]         fpu_op_q, fpu_op_d;
    logic [4:0]         rd_q, rd_d;
    logic               wb_en_q, wb_en_d;
    logic [4:0]         wb_rd_q, wb_rd_d;
    logic [31:0]        wb_data_q, wb_data_d;
    logic               cc_q, cc_d;
    logic [2:0]         flags_q, flags_d;

    logic               accept;
    logic               launch;
    logic [3:0]         l_op;
    logic [31:0]        l_a, l_b;
    logic [4:0]         l_rd;
    logic [2:0]         new_flags;

`ifdef FPU_SEQ_QUEUE_EN
    logic               q_full_q, q_full_d;
    logic [3:0]         q_op_q, q_op_d;
    logic [31:0]        q_a_q, q_a_d, q_b_q, q_b_d;
    logic [4:0]         q_rd_q, q_rd_d;

    assign req_ready = (state_q == IDLE) || !q_full_q;
    assign busy      = (state_q != IDLE) || q_full_q;
`else
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
`endif

    assign accept = req_valid && req_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fpu_a_d   = fpu_a_q;
        fpu_b_d   = fpu_b_q;
        fpu_op_d  = fpu_op_q;
        rd_d      = rd_q;
        wb_en_d   = 1'b0;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        cc_d      = cc_q;
        new_flags = 3'b000;
        launch    = 1'b0;
        l_op      = req_op;
        l_a       = req_a;
        l_b       = req_b;
        l_rd      = req_rd;
`ifdef FPU_SEQ_QUEUE_EN
        q_full_d  = q_full_q;
        q_op_d    = q_op_q;
        q_a_d     = q_a_q;
        q_b_d     = q_b_q;
        q_rd_d    = q_rd_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) launch = 1'b1;
            end
            EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                // FPU outputs are only trusted on the last held cycle
                if (cnt_q == CNT_W'(1)) begin
                    state_d   = DONE;
                    new_flags = {fpu_invalid, fpu_overflow, fpu_underflow};
                    if (is_write(fpu_op_q)) begin
                        wb_en_d   = 1'b1;
                        wb_rd_d   = rd_q;
                        wb_data_d = fpu_result;
                    end
                    if (is_cmp(fpu_op_q)) cc_d = fpu_cc;
                end
`ifdef FPU_SEQ_QUEUE_EN
                if (accept) begin
                    q_full_d = 1'b1;
                    q_op_d   = req_op;
                    q_a_d    = req_a;
                    q_b_d    = req_b;
                    q_rd_d   = req_rd;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
`ifdef FPU_SEQ_QUEUE_EN
                // A buffered op goes first; with an empty buffer a fresh accept launches directly
                if (q_full_q) begin
                    launch   = 1'b1;
                    l_op     = q_op_q;
                    l_a      = q_a_q;
                    l_b      = q_b_q;
                    l_rd     = q_rd_q;
                    q_full_d = 1'b0;
                end else if (accept) begin
                    launch = 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (launch) begin
            state_d  = EXEC;
            fpu_a_d  = l_a;
            fpu_b_d  = l_b;
            fpu_op_d = l_op;
            rd_d     = l_rd;
            cnt_d    = op_cnt(l_op);
        end

        // Newly captured flags survive a coincident clear
        flags_d = (flags_clr ? 3'b000 : flags_q) | new_flags;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fpu_a_q   <= '0;
            fpu_b_q   <= '0;
            fpu_op_q  <= '0;
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            cc_q      <= 1'b0;
            flags_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fpu_a_q   <= fpu_a_d;
            fpu_b_q   <= fpu_b_d;
            fpu_op_q  <= fpu_op_d;
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            cc_q      <= cc_d;
            flags_q   <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        rd_q <= rd_d;
`ifdef FPU_SEQ_QUEUE_EN
        q_op_q <= q_op_d;
        q_a_q  <= q_a_d;
        q_b_q  <= q_b_d;
        q_rd_q <= q_rd_d;
`endif
    end

`ifdef FPU_SEQ_QUEUE_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_full_q <= 1'b0;
        else     q_full_q <= q_full_d;
    end
`endif

    assign fpu_a        = fpu_a_q;
    assign fpu_b        = fpu_b_q;
    assign fpu_op       = fpu_op_q;
    assign wb_en        = wb_en_q;
    assign wb_rd        = wb_rd_q;
    assign wb_data      = wb_data_q;
    assign cc_out       = cc_q;
    assign flags_sticky = flags_q;

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Self-checking bench for fpu_op_sequencer: directed vector table, hand-written corner sequences,
// and random traffic checked cycle by cycle against a transaction-level schedule model.
module tb_fpu_op_sequencer;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_rd;
    logic [31:0] fpu_a, fpu_b;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_result;
    logic        fpu_cc, fpu_invalid, fpu_overflow, fpu_underflow;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        cc_out;
    logic        busy;
    logic [2:0]  flags_sticky;
    logic        flags_clr;

    always #5 clk = ~clk;

    fpu_op_sequencer #(.LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_op(fpu_op),
        .fpu_result(fpu_result), .fpu_cc(fpu_cc), .fpu_invalid(fpu_invalid),
        .fpu_overflow(fpu_overflow), .fpu_underflow(fpu_underflow),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .cc_out(cc_out),
        .busy(busy), .flags_sticky(flags_sticky), .flags_clr(flags_clr)
    );

    // Stand-in FPU: exact answers for the named operand pairs, a hash otherwise.
    // Returns {cc, invalid, overflow, underflow, result}.
    function automatic logic [35:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        logic [31:0] h, r;
        logic cc, inv, ovf, unf;
        h   = (a * 32'h9E3779B1) ^ {b[15:0], b[31:16]} ^ {28'd0, op};
        r   = h;
        cc  = h[5];
        inv = 1'b0;
        ovf = h[9] & h[2];
        unf = h[11] & h[4];
        case (op)
            4'd1: begin
                if (a == 32'h3F800000 && b == 32'h40000000) begin
                    r = 32'h40400000; ovf = 1'b0; unf = 1'b0;
                end else if (a == 32'h7F7FFFFF && b == 32'h7F7FFFFF) begin
                    r = 32'h7F800000; ovf = 1'b1; unf = 1'b0;
                end
            end
            4'd2: begin
                if (a == 32'h40400000 && b == 32'h3F800000) begin
                    r = 32'h40000000; ovf = 1'b0; unf = 1'b0;
                end
            end
            4'd3: begin cc = (a == b); ovf = 1'b0; unf = 1'b0; end
            4'd4: begin cc = (a <  b); ovf = 1'b0; unf = 1'b0; end
            4'd5: begin cc = (a <= b); ovf = 1'b0; unf = 1'b0; end
            4'd7: begin cc = (a >= b); ovf = 1'b0; unf = 1'b0; end
            4'd8: begin cc = (a >  b); ovf = 1'b0; unf = 1'b0; end
            4'd6: begin r = a; ovf = 1'b0; unf = 1'b0; end
            default: begin r = 32'd0; inv = 1'b1; ovf = 1'b0; unf = 1'b0; end
        endcase
        return {cc, inv, ovf, unf, r};
    endfunction

    assign {fpu_cc, fpu_invalid, fpu_overflow, fpu_underflow, fpu_result} =
        fpu_model(fpu_a, fpu_b, fpu_op);

    function automatic int op_lat(input logic [3:0] op);
        if (op == 4'd1 || op == 4'd2) return (LAT < 1) ? 1 : LAT;
        return 1;
    endfunction

    function automatic logic op_wb(input logic [3:0] op);
        return op == 4'd1 || op == 4'd2 || op == 4'd6;
    endfunction

    function automatic logic op_cmp(input logic [3:0] op);
        return op == 4'd3 || op == 4'd4 || op == 4'd5 || op == 4'd7 || op == 4'd8;
    endfunction

    // Schedule model: each accepted op occupies [launch+1, done-1] in EXEC and shows results at done.
    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        int          launch;
        int          done;
    } txn_t;

    txn_t        pend[$];
    int          last_done;
`ifdef FPU_SEQ_QUEUE_EN
    int          q_launch;
`endif
    logic [2:0]  m_flags;
    logic        m_cc;
    logic [4:0]  m_wb_rd;
    logic [31:0] m_wb_data;
    logic        m_clr_prev;

    int cyc;
    int tests, fails;

    logic        obs_ready, obs_busy, obs_wb_en, obs_cc;
    logic [4:0]  obs_wb_rd;
    logic [31:0] obs_wb_data;
    logic [2:0]  obs_flags;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        last_done  = -100;
`ifdef FPU_SEQ_QUEUE_EN
        q_launch   = -100;
`endif
        m_flags    = 3'b000;
        m_cc       = 1'b0;
        m_wb_rd    = 5'd0;
        m_wb_data  = 32'd0;
        m_clr_prev = 1'b0;
    endtask

    // One clock: check outputs of the new cycle, then drive this cycle's inputs.
    task automatic cycle_step(input logic v, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [4:0] rd, input logic clr,
                              output logic acc);
        logic        e_wb, e_ready, e_busy;
        logic [2:0]  newf;
        logic [35:0] fm;
        txn_t        h, t;
        int          launch;
        @(negedge clk);
        cyc++;
        e_wb = 1'b0;
        newf = 3'b000;
        if (pend.size() > 0 && pend[0].done == cyc) begin
            h  = pend.pop_front();
            fm = fpu_model(h.a, h.b, h.op);
            if (op_wb(h.op)) begin
                e_wb      = 1'b1;
                m_wb_rd   = h.rd;
                m_wb_data = fm[31:0];
            end
            if (op_cmp(h.op)) m_cc = fm[35];
            newf = fm[34:32];
        end
        m_flags = (m_clr_prev ? 3'b000 : m_flags) | newf;
        e_busy  = (cyc <= last_done);
`ifdef FPU_SEQ_QUEUE_EN
        e_ready = (cyc > last_done) || (cyc > q_launch);
`else
        e_ready = (cyc > last_done);
`endif
        obs_ready   = req_ready;
        obs_busy    = busy;
        obs_wb_en   = wb_en;
        obs_wb_rd   = wb_rd;
        obs_wb_data = wb_data;
        obs_cc      = cc_out;
        obs_flags   = flags_sticky;
        check("req_ready", obs_ready, e_ready);
        check("busy", obs_busy, e_busy);
        check("wb_en", obs_wb_en, e_wb);
        check("wb_rd", obs_wb_rd, m_wb_rd);
        check("wb_data", obs_wb_data, m_wb_data);
        check("cc_out", obs_cc, m_cc);
        check("flags_sticky", obs_flags, m_flags);
        if (pend.size() > 0 && pend[0].launch < cyc && cyc < pend[0].done) begin
            check("fpu_a_held", fpu_a, pend[0].a);
            check("fpu_b_held", fpu_b, pend[0].b);
            check("fpu_op_held", fpu_op, pend[0].op);
        end
        req_valid = v;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
        flags_clr = clr;
        acc = v && e_ready;
        if (acc) begin
            launch = (cyc > last_done) ? cyc : last_done;
            t = '{op: op, a: a, b: b, rd: rd, launch: launch, done: launch + op_lat(op) + 1};
            pend.push_back(t);
`ifdef FPU_SEQ_QUEUE_EN
            if (launch > cyc) q_launch = launch;
`endif
            last_done = t.done;
        end
        m_clr_prev = clr;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) cycle_step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, acc);
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [4:0]  rd;
        logic        exp_wb;
        logic [31:0] exp_data;
        int          exp_lat;
        logic        exp_cc;
        logic [2:0]  exp_flags;
    } vec_t;

    vec_t vecs[11];

    task automatic run_vec(input int idx);
        logic        acc;
        int          wb_cnt, wb_k, busy_cnt;
        logic [31:0] wb_dat;
        logic [4:0]  wb_r;
        vec_t        v;
        v = vecs[idx];
        wb_cnt = 0; wb_k = -1; busy_cnt = 0; wb_dat = 32'd0; wb_r = 5'd0;
        cycle_step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
        cycle_step(1'b1, v.op, v.a, v.b, v.rd, 1'b0, acc);
        for (int k = 1; k <= 8; k++) begin
            cycle_step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, acc);
            if (obs_busy) busy_cnt++;
            if (obs_wb_en) begin
                wb_cnt++;
                wb_k   = k;
                wb_dat = obs_wb_data;
                wb_r   = obs_wb_rd;
            end
        end
        check($sformatf("v%0d_wb_count", idx), wb_cnt, {31'd0, v.exp_wb});
        check($sformatf("v%0d_busy_cycles", idx), busy_cnt, v.exp_lat);
        if (v.exp_wb) begin
            check($sformatf("v%0d_wb_cycle", idx), wb_k, v.exp_lat);
            check($sformatf("v%0d_wb_data", idx), wb_dat, v.exp_data);
            check($sformatf("v%0d_wb_rd", idx), wb_r, v.rd);
        end
        check($sformatf("v%0d_cc", idx), obs_cc, v.exp_cc);
        check($sformatf("v%0d_flags", idx), obs_flags, v.exp_flags);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        acc;
        logic        pv;
        logic [3:0]  pop;
        logic [31:0] pa, pb;
        logic [4:0]  prd;
        logic        clr;
        int          r, wbn, acc1_k, acc2_k, wb1_k, wb2_k, c0;
        logic        acc1, acc2, drv_v;
        logic [3:0]  drv_op;
        logic [31:0] drv_a;
        logic [4:0]  drv_rd;
        logic [31:0] wb1_d, wb2_d;

        //        op     a             b             rd    wb    data          lat  cc    flags
        vecs[0]  = '{4'd1, 32'h3F800000, 32'h40000000, 5'd5, 1'b1, 32'h40400000, 4, 1'b0, 3'b000};
        vecs[1]  = '{4'd4, 32'h3F800000, 32'h40000000, 5'd3, 1'b0, 32'h0,        2, 1'b1, 3'b000};
        vecs[2]  = '{4'd6, 32'h3F800000, 32'h12345678, 5'd1, 1'b1, 32'h3F800000, 2, 1'b1, 3'b000};
        vecs[3]  = '{4'd3, 32'h3F800000, 32'h40000000, 5'd2, 1'b0, 32'h0,        2, 1'b0, 3'b000};
        vecs[4]  = '{4'd5, 32'h40000000, 32'h3F800000, 5'd4, 1'b0, 32'h0,        2, 1'b0, 3'b000};
        vecs[5]  = '{4'd7, 32'h40000000, 32'h3F800000, 5'd6, 1'b0, 32'h0,        2, 1'b1, 3'b000};
        vecs[6]  = '{4'd0, 32'h11111111, 32'h22222222, 5'd7, 1'b0, 32'h0,        2, 1'b1, 3'b100};
        vecs[7]  = '{4'd8, 32'h3F800000, 32'h40000000, 5'd8, 1'b0, 32'h0,        2, 1'b0, 3'b000};
        vecs[8]  = '{4'd1, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd9, 1'b1, 32'h7F800000, 4, 1'b0, 3'b010};
        vecs[9]  = '{4'd2, 32'h40400000, 32'h3F800000, 5'd31, 1'b1, 32'h40000000, 4, 1'b0, 3'b000};
        vecs[10] = '{4'hF, 32'h3F800000, 32'h3F800000, 5'd10, 1'b0, 32'h0,       2, 1'b0, 3'b100};

        tests = 0; fails = 0; cyc = 0;
        rst = 1'b1;
        req_valid = 1'b0; req_op = 4'd0; req_a = 32'd0; req_b = 32'd0; req_rd = 5'd0;
        flags_clr = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", req_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_wb_en", wb_en, 1'b0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_cc", cc_out, 1'b0);
        check("rst_flags", flags_sticky, 3'b000);
        check("rst_fpu_op", fpu_op, 4'd0);
        check("rst_fpu_a", fpu_a, 32'd0);
        rst = 1'b0;
        model_reset();

        idle(3);
        for (int i = 0; i < 11; i++) run_vec(i);

        // Clear, then a coincident clear on the capture edge of an invalid op
        cycle_step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
        cycle_step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, acc);
        check("clr_pulse", obs_flags, 3'b000);
        idle(3);
        check("idle_no_sample", obs_flags, 3'b000);
        cycle_step(1'b1, 4'd1, 32'h7F7FFFFF, 32'h7F7FFFFF, 5'd11, 1'b0, acc);
        idle(6);
        check("ovf_flag", obs_flags, 3'b010);
        cycle_step(1'b1, 4'd0, 32'h5, 32'h6, 5'd12, 1'b0, acc);
        cycle_step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b1, acc);
        cycle_step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, acc);
        check("clr_vs_set", obs_flags, 3'b100);
        idle(2);

        // Async reset during the second EXEC cycle of an add
        cycle_step(1'b1, 4'd7, 32'h40000000, 32'h3F800000, 5'd13, 1'b0, acc);
        idle(3);
        cycle_step(1'b1, 4'd1, 32'h3F800000, 32'h40000000, 5'd7, 1'b0, acc);
        idle(2);
        #2 rst = 1'b1;
        #1;
        check("arst_fpu_a", fpu_a, 32'd0);
        check("arst_fpu_b", fpu_b, 32'd0);
        check("arst_fpu_op", fpu_op, 4'd0);
        check("arst_wb_en", wb_en, 1'b0);
        check("arst_wb_rd", wb_rd, 5'd0);
        check("arst_wb_data", wb_data, 32'd0);
        check("arst_cc", cc_out, 1'b0);
        check("arst_flags", flags_sticky, 3'b000);
        check("arst_busy", busy, 1'b0);
        check("arst_ready", req_ready, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        wbn = 0;
        for (int k = 0; k < 6; k++) begin
            cycle_step(1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0, acc);
            if (obs_wb_en) wbn++;
        end
        check("arst_no_wb", wbn, 0);

        // Back-to-back movs with the request held until accepted
        acc1 = 1'b0; acc2 = 1'b0;
        acc1_k = -1; acc2_k = -1; wb1_k = -1; wb2_k = -1;
        wb1_d = 32'd0; wb2_d = 32'd0;
        c0 = cyc + 1;
        for (int k = 0; k < 10; k++) begin
            drv_v = 1'b0; drv_op = 4'd0; drv_a = 32'd0; drv_rd = 5'd0;
            if (!acc1) begin
                drv_v = 1'b1; drv_op = 4'd6; drv_a = 32'h3F800000; drv_rd = 5'd1;
            end else if (!acc2) begin
                drv_v = 1'b1; drv_op = 4'd6; drv_a = 32'h40000000; drv_rd = 5'd2;
            end
            cycle_step(drv_v, drv_op, drv_a, 32'd0, drv_rd, 1'b0, acc);
            if (obs_wb_en && obs_wb_rd == 5'd1) begin wb1_k = cyc - c0; wb1_d = obs_wb_data; end
            if (obs_wb_en && obs_wb_rd == 5'd2) begin wb2_k = cyc - c0; wb2_d = obs_wb_data; end
            if (drv_v && obs_ready) begin
                if (!acc1) begin acc1 = 1'b1; acc1_k = cyc - c0; end
                else begin acc2 = 1'b1; acc2_k = cyc - c0; end
            end
        end
        check("b2b_acc1_cycle", acc1_k, 0);
        check("b2b_wb1_cycle", wb1_k, 2);
        check("b2b_wb1_data", wb1_d, 32'h3F800000);
        check("b2b_wb2_data", wb2_d, 32'h40000000);
`ifdef FPU_SEQ_QUEUE_EN
        check("b2b_acc2_cycle", acc2_k, 1);
        check("b2b_wb2_cycle", wb2_k, 4);
`else
        check("b2b_acc2_cycle", acc2_k, 3);
        check("b2b_wb2_cycle", wb2_k, 5);
`endif

        // Random traffic; the requester holds each request until it is taken
        pv = 1'b0; pop = 4'd0; pa = 32'd0; pb = 32'd0; prd = 5'd0;
        for (int i = 0; i < 1500; i++) begin
            if (!pv && $urandom_range(0, 9) < 6) begin
                pv  = 1'b1;
                r   = $urandom_range(0, 9);
                pop = (r == 9) ? 4'hF : 4'(r);
                pa  = $urandom;
                pb  = ($urandom_range(0, 3) == 0) ? pa : $urandom;
                prd = 5'($urandom_range(0, 31));
            end
            clr = ($urandom_range(0, 19) == 0);
            cycle_step(pv, pop, pa, pb, prd, clr, acc);
            if (acc) pv = 1'b0;
        end
        idle(8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
